// File: rtl/cacc_v2_pkg.sv
// Shared constants and clip-bound helpers for the CACC v2 accumulation datapath.
package cacc_v2_pkg;

  localparam int unsigned DEF_NUM_LANES = 16;
  localparam int unsigned DEF_IN_W      = 22;
  localparam int unsigned DEF_PSUM_W    = 34;
  localparam int unsigned DEF_OUT_W     = 32;
  localparam int unsigned DEF_ADDR_W    = 6;
  localparam int unsigned DEF_CNT_W     = 7;

  localparam int unsigned TRUNC_W   = 5;
  localparam int unsigned PD_W      = 2;
  localparam int unsigned SAT_CNT_W = 32;

  // Bit positions inside dlv_pd
  localparam int unsigned STRIPE_END = 0;
  localparam int unsigned LAYER_END  = 1;

  localparam int unsigned MAX_W = 128;
  typedef logic signed [MAX_W-1:0] wide_t;

  function automatic wide_t sat_max(input int unsigned w);
    wide_t one;
    one = wide_t'(1);
    return (one <<< (w - 1)) - one;
  endfunction

  function automatic wide_t sat_min(input int unsigned w);
    return ~sat_max(w);
  endfunction

endpackage

// File: rtl/cacc_accu_lane.sv
// One accumulation lane: stage-1 add, stage-2 writeback clip or round/truncate/clip.
module cacc_accu_lane
  import cacc_v2_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned PSUM_W = DEF_PSUM_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               s1_load,
  input  logic               enable,
  input  logic [IN_W-1:0]    data,
  input  logic [PSUM_W-1:0]  psum,
  input  logic               psum_vld,
  input  logic [TRUNC_W-1:0] truncate,
  input  logic               wr_load,
  input  logic               dlv_load,
  output logic [PSUM_W-1:0]  wr_data,
  output logic [OUT_W-1:0]   dlv_data,
  output logic               sat_bit
);

  localparam int unsigned SW = PSUM_W + 1;
  // Room for the sum plus a rounding term of up to 2^30 without overflow
  localparam int unsigned RW = ((SW > 32) ? SW : 32) + 1;

  localparam logic signed [SW-1:0] PMAX = SW'(sat_max(PSUM_W));
  localparam logic signed [SW-1:0] PMIN = SW'(sat_min(PSUM_W));
  localparam logic signed [RW-1:0] OMAX = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] OMIN = RW'(sat_min(OUT_W));

  logic signed [SW-1:0] s_next, psum_term, s1_sum;
  logic                 s1_en;
  logic signed [RW-1:0] s_ext, rnd, r;
  logic [PSUM_W-1:0]    wr_next;
  logic [OUT_W-1:0]     dlv_next;
  logic                 clip_hi, clip_lo;

  always_comb begin
    s_next    = '0;
    psum_term = psum_vld ? SW'(signed'(psum)) : '0;
    if (enable) s_next = SW'(signed'(data)) + psum_term;
  end

  always_ff @(posedge clk) begin
    if (s1_load) begin
      s1_sum <= s_next;
      s1_en  <= enable;
    end
  end

  always_comb begin
    wr_next = PSUM_W'(s1_sum);
    if (s1_sum > PMAX) wr_next = PSUM_W'(PMAX);
    else if (s1_sum < PMIN) wr_next = PSUM_W'(PMIN);

    s_ext = RW'(s1_sum);
    rnd   = '0;
    if (truncate != '0) rnd = RW'(1) << (truncate - 5'd1);
    r       = (s_ext + rnd) >>> truncate;
    clip_hi = (r > OMAX);
    clip_lo = (r < OMIN);
    dlv_next = OUT_W'(r);
    if (clip_hi) dlv_next = OUT_W'(OMAX);
    else if (clip_lo) dlv_next = OUT_W'(OMIN);
  end

  always_ff @(posedge clk) begin
    if (wr_load) wr_data <= wr_next;
    if (dlv_load) begin
      dlv_data <= dlv_next;
      sat_bit  <= (clip_hi | clip_lo) & s1_en;
    end
  end

endmodule

// File: rtl/cacc_accu_calc_v2.sv
// CACC v2 accumulation top: lane array, writeback/delivery routing, per-layer saturation counter.
module cacc_accu_calc_v2
  import cacc_v2_pkg::*;
#(
  parameter int unsigned NUM_LANES = DEF_NUM_LANES,
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned PSUM_W    = DEF_PSUM_W,
  parameter int unsigned OUT_W     = DEF_OUT_W,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                        nvdla_core_clk,
  input  logic                        nvdla_core_rstn,
  input  logic                        in_valid,
  input  logic [NUM_LANES-1:0]        in_mask,
  input  logic [NUM_LANES*IN_W-1:0]   in_data,
  input  logic [NUM_LANES*PSUM_W-1:0] in_psum,
  input  logic                        in_psum_vld,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic                        in_channel_end,
  input  logic                        in_stripe_end,
  input  logic                        in_layer_end,
  input  logic [TRUNC_W-1:0]          cfg_truncate,
  output logic                        abuf_wr_en,
  output logic [ADDR_W-1:0]           abuf_wr_addr,
  output logic [NUM_LANES*PSUM_W-1:0] abuf_wr_data,
  output logic                        dlv_valid,
  output logic [NUM_LANES*OUT_W-1:0]  dlv_data,
  output logic [PD_W-1:0]             dlv_pd,
  output logic [SAT_CNT_W-1:0]        dp2reg_sat_count,
  output logic                        sat_count_done
);

  logic              s1_valid, s1_ce, s1_stripe, s1_layer;
  logic [ADDR_W-1:0] s1_addr;
  logic              wr_load, dlv_load;
  logic [NUM_LANES-1:0] sat_bits;
  logic [CNT_W-1:0]     pop;
  logic [SAT_CNT_W:0]   cnt_sum;
  logic                 layer_start, layer_done;

  assign wr_load  = s1_valid & ~s1_ce;
  assign dlv_load = s1_valid & s1_ce;

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) s1_valid <= 1'b0;
    else s1_valid <= in_valid;
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (in_valid) begin
      s1_ce     <= in_channel_end;
      s1_stripe <= in_stripe_end;
      s1_layer  <= in_layer_end;
      s1_addr   <= in_addr;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    cacc_accu_lane #(
      .IN_W  (IN_W),
      .PSUM_W(PSUM_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk     (nvdla_core_clk),
      .s1_load (in_valid),
      .enable  (in_mask[g]),
      .data    (in_data[g*IN_W +: IN_W]),
      .psum    (in_psum[g*PSUM_W +: PSUM_W]),
      .psum_vld(in_psum_vld),
      .truncate(cfg_truncate),
      .wr_load (wr_load),
      .dlv_load(dlv_load),
      .wr_data (abuf_wr_data[g*PSUM_W +: PSUM_W]),
      .dlv_data(dlv_data[g*OUT_W +: OUT_W]),
      .sat_bit (sat_bits[g])
    );
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      abuf_wr_en   <= 1'b0;
      dlv_valid    <= 1'b0;
      abuf_wr_addr <= '0;
      dlv_pd       <= '0;
    end else begin
      abuf_wr_en <= wr_load;
      dlv_valid  <= dlv_load;
      if (wr_load) abuf_wr_addr <= s1_addr;
      if (dlv_load) dlv_pd <= {s1_layer, s1_stripe};
    end
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) pop = pop + CNT_W'(sat_bits[i]);
    cnt_sum    = {1'b0, dp2reg_sat_count} + (SAT_CNT_W+1)'(pop);
    layer_done = dlv_pd[STRIPE_END] & dlv_pd[LAYER_END];
  end

  // First delivery of a layer loads instead of accumulating; the sum sticks at all-ones
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rstn) begin
      dp2reg_sat_count <= '0;
      layer_start      <= 1'b1;
      sat_count_done   <= 1'b0;
    end else begin
      sat_count_done <= 1'b0;
      if (dlv_valid) begin
        if (layer_start) dp2reg_sat_count <= SAT_CNT_W'(pop);
        else dp2reg_sat_count <= cnt_sum[SAT_CNT_W] ? '1 : cnt_sum[SAT_CNT_W-1:0];
        layer_start    <= layer_done;
        sat_count_done <= layer_done;
      end
    end
  end

endmodule
